// File: rtl/harness_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : harness_pkg
//  Description : Shared register offsets, sequencer state encoding and dwell
//                limits for the project sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package harness_pkg;

    // Register offsets within the block (byte addresses)
    localparam logic [7:0] c_OFF_CTRL   = 8'h00;
    localparam logic [7:0] c_OFF_MASK   = 8'h04;
    localparam logic [7:0] c_OFF_DWELL  = 8'h08;
    localparam logic [7:0] c_OFF_STATUS = 8'h0C;

    // Shortest dwell honoured regardless of the DWELL register contents
    localparam logic [31:0] c_DWELL_MIN   = 32'd16;
    localparam logic [31:0] c_DWELL_RESET = 32'h0010_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    // Effective dwell length: the programmed value clamped to the minimum
    function automatic logic [31:0] eff_dwell(input logic [31:0] dwell);
        return (dwell < c_DWELL_MIN) ? c_DWELL_MIN : dwell;
    endfunction

endpackage
`default_nettype wire

// File: rtl/project_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : project_sequencer_if
//  Description : Wishbone slave bus bundle for the project sequencer register
//                block. Signal names keep the harness' Wishbone naming.
//  Revision    : 1.0 - initial release
// ============================================================================
interface project_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/next_project_picker.sv
`default_nettype none
// ============================================================================
//  Module      : next_project_picker
//  Description : Combinational rotate-priority search: returns the lowest set
//                mask bit strictly above the current project, wrapping to bit
//                0. The current project itself is the last candidate.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_project_picker #(
    parameter int NUM_PROJECTS = 8
) (
    input  wire logic [7:0] i_mask,
    input  wire logic [7:0] i_current,
    output logic      [7:0] o_next,
    output logic            o_found
);

    int w_idx;

    // Walk candidates current+1, current+2, ... modulo NUM_PROJECTS
    always_comb begin
        o_next  = i_current;
        o_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_PROJECTS; i++) begin
            w_idx = (int'(i_current) + i) % NUM_PROJECTS;
            if (!o_found && i_mask[w_idx[2:0]]) begin
                o_found = 1'b1;
                o_next  = 8'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/project_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : project_sequencer
//  Description : Wishbone-controlled project switcher. Rotates through the
//                enabled projects after a programmable dwell, blanking IOs and
//                holding the incoming project in reset around every switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module project_sequencer
    import harness_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0600,
    parameter int          NUM_PROJECTS = 8,
    parameter int          GUARD_CYCLES = 4,
    parameter int          RST_CYCLES   = 8
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_rst_i,
    project_sequencer_if.slave wb,
    output logic [7:0]         active_project,
    output logic               io_blank,
    output logic               proj_reset_o,
    output logic               switch_done
);

    localparam logic [7:0]  c_PROJ_MASK  = 8'((1 << NUM_PROJECTS) - 1);
    localparam logic [31:0] c_GUARD_LAST = 32'(GUARD_CYCLES - 1);
    localparam logic [31:0] c_RST_LAST   = 32'(RST_CYCLES - 1);

    // Register file
    logic        r_auto_en;
    logic [2:0]  r_manual_target;
    logic [7:0]  r_mask;
    logic [31:0] r_dwell;
    logic        r_pending;
    logic [2:0]  r_pend_target;
    logic        r_ack;
    logic [31:0] r_dat;

    // Sequencer state
    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_active, w_active_nxt;
    logic [7:0]  r_target, w_target_nxt;
    logic        r_switch_done, w_done_nxt;
    logic        w_take_pending;

    logic [31:0] w_off;
    logic        w_hit;
    logic        w_access;
    logic [31:0] w_rdata;
    logic [7:0]  w_mask_valid;
    logic [7:0]  w_next;
    logic        w_next_found;
    logic        w_terminal;

    // The whole 256-byte window is acked; only four offsets are mapped
    assign w_off    = wb.wbs_adr_i - BASE_ADDR;
    assign w_hit    = wb.wbs_cyc_i && wb.wbs_stb_i && (w_off[31:8] == 24'd0);
    assign w_access = w_hit && !r_ack;

    assign w_mask_valid = r_mask & c_PROJ_MASK;
    // A counter already past a freshly lowered dwell still terminates at once
    assign w_terminal   = (r_cnt >= (eff_dwell(r_dwell) - 32'd1));

    next_project_picker #(
        .NUM_PROJECTS (NUM_PROJECTS)
    ) u_picker (
        .i_mask    (w_mask_valid),
        .i_current (r_active),
        .o_next    (w_next),
        .o_found   (w_next_found)
    );

    // Read-data mux; unmapped offsets read as zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_off[7:0])
            c_OFF_CTRL:   w_rdata = {21'd0, r_manual_target, 7'd0, r_auto_en};
            c_OFF_MASK:   w_rdata = {24'd0, r_mask};
            c_OFF_DWELL:  w_rdata = r_dwell;
            c_OFF_STATUS: w_rdata = {14'd0, r_state, 8'd0, r_active};
            default:      w_rdata = 32'd0;
        endcase
    end

    // Wishbone register file, single-cycle ack and manual-request latch
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_auto_en       <= 1'b0;
            r_manual_target <= 3'd0;
            r_mask          <= 8'd0;
            r_dwell         <= c_DWELL_RESET;
            r_pending       <= 1'b0;
            r_pend_target   <= 3'd0;
            r_ack           <= 1'b0;
            r_dat           <= 32'd0;
        end else begin
            r_ack <= w_access;
            r_dat <= 32'd0;
            if (w_take_pending) begin
                r_pending <= 1'b0;
            end
            if (w_access) begin
                if (!wb.wbs_we_i) begin
                    r_dat <= w_rdata;
                end else if (wb.wbs_sel_i == 4'hF) begin
                    case (w_off[7:0])
                        c_OFF_CTRL: begin
                            r_auto_en       <= wb.wbs_dat_i[0];
                            r_manual_target <= wb.wbs_dat_i[10:8];
                            // A new request overrides one being consumed now
                            if (wb.wbs_dat_i[1]) begin
                                r_pending     <= 1'b1;
                                r_pend_target <= wb.wbs_dat_i[10:8];
                            end
                        end
                        c_OFF_MASK:  r_mask  <= wb.wbs_dat_i[7:0];
                        c_OFF_DWELL: r_dwell <= wb.wbs_dat_i;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Sequencer next-state: manual request first, then auto rotation
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_active_nxt   = r_active;
        w_target_nxt   = r_target;
        w_done_nxt     = 1'b0;
        w_take_pending = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 32'd0;
                if (r_pending) begin
                    w_take_pending = 1'b1;
                    w_target_nxt   = {5'd0, r_pend_target};
                    w_state_nxt    = ST_GUARD;
                end else if (r_auto_en && (w_mask_valid != 8'd0)) begin
                    w_target_nxt = w_next;
                    w_state_nxt  = ST_GUARD;
                end
            end
            ST_RUN: begin
                if (r_pending) begin
                    w_take_pending = 1'b1;
                    w_target_nxt   = {5'd0, r_pend_target};
                    w_cnt_nxt      = 32'd0;
                    w_state_nxt    = ST_GUARD;
                end else if (!r_auto_en) begin
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = ST_IDLE;
                end else if (w_terminal) begin
                    w_cnt_nxt = 32'd0;
                    if (w_next_found && (w_next != r_active)) begin
                        w_target_nxt = w_next;
                        w_state_nxt  = ST_GUARD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_GUARD: begin
                if (r_cnt == c_GUARD_LAST) begin
                    w_active_nxt = r_target;
                    w_cnt_nxt    = 32'd0;
                    w_state_nxt  = ST_RESET;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_RESET: begin
                if (r_cnt == c_RST_LAST) begin
                    w_cnt_nxt   = 32'd0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 32'd0;
            r_active      <= 8'd0;
            r_target      <= 8'd0;
            r_switch_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_active      <= w_active_nxt;
            r_target      <= w_target_nxt;
            r_switch_done <= w_done_nxt;
        end
    end

    assign active_project = r_active;
    assign io_blank       = (r_state == ST_GUARD) || (r_state == ST_RESET);
    assign proj_reset_o   = (r_state == ST_RESET);
    assign switch_done    = r_switch_done;
    assign wb.wbs_ack_o   = r_ack;
    assign wb.wbs_dat_o   = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_project_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_project_sequencer
//  Description : Scoreboard bench for project_sequencer: directed register
//                traffic and rotation scenarios, with a monitor comparing read
//                data, switch targets and blanking/reset pulse lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_project_sequencer;

    localparam logic [31:0] c_BASE = 32'h3000_0600;

    logic       wb_clk_i;
    logic       wb_rst_i;
    logic [7:0] active_project;
    logic       io_blank;
    logic       proj_reset_o;
    logic       switch_done;

    project_sequencer_if bus_if ();

    project_sequencer #(
        .BASE_ADDR    (c_BASE),
        .NUM_PROJECTS (8),
        .GUARD_CYCLES (4),
        .RST_CYCLES   (8)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wb             (bus_if),
        .active_project (active_project),
        .io_blank       (io_blank),
        .proj_reset_o   (proj_reset_o),
        .switch_done    (switch_done)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  sw_q[$];
    int          blank_len = 0;
    int          prst_len  = 0;

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: read data, switch targets and pulse lengths
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            blank_len = 0;
            prst_len  = 0;
        end else begin
            if (bus_if.wbs_ack_o && !bus_if.wbs_we_i) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=%h required=none", bus_if.wbs_dat_o);
                end else begin
                    chk("rd_data", bus_if.wbs_dat_o, rd_q.pop_front());
                end
            end
            if (switch_done) begin
                if (sw_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL switch_unexpected actual=%0d required=none", active_project);
                end else begin
                    chk("switch_proj", {24'd0, active_project}, {24'd0, sw_q.pop_front()});
                end
            end
            if (io_blank) blank_len++;
            else if (blank_len != 0) begin
                chk("blank_len", blank_len, 12);
                blank_len = 0;
            end
            if (proj_reset_o) prst_len++;
            else if (prst_len != 0) begin
                chk("prst_len", prst_len, 8);
                prst_len = 0;
            end
        end
    end

    // One bus cycle; ack must arrive exactly on the cycle after the request
    task automatic bus(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                       input logic [31:0] data, input logic exp_ack);
        int got_at;
        got_at = -1;
        @(posedge wb_clk_i); #1;
        bus_if.wbs_adr_i = addr;
        bus_if.wbs_we_i  = we;
        bus_if.wbs_sel_i = sel;
        bus_if.wbs_dat_i = data;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            if (got_at < 0 && bus_if.wbs_ack_o) got_at = i;
            if (got_at >= 0 && i == got_at) begin
                @(posedge wb_clk_i); #1;
                bus_if.wbs_cyc_i = 1'b0;
                bus_if.wbs_stb_i = 1'b0;
                bus_if.wbs_we_i  = 1'b0;
                @(negedge wb_clk_i);
                chk("ack_one_cycle", {31'd0, bus_if.wbs_ack_o}, 32'd0);
                i = 4;
            end
        end
        chk("ack_timing", got_at, exp_ack ? 32'd1 : 32'hFFFF_FFFF);
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        bus(c_BASE + {24'd0, off}, 1'b1, 4'hF, data, 1'b1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus(c_BASE + {24'd0, off}, 1'b0, 4'hF, 32'd0, 1'b1);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (switch_done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Cycles from the switch_done cycle until blanking starts again
    task automatic measure_dwell(input string name, input int exp);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge wb_clk_i);
            n++;
            if (io_blank) seen = 1'b1;
        end
        chk(name, n, exp);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
    endtask

    initial begin
        logic seen;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
        bus_if.wbs_sel_i = 4'h0;
        bus_if.wbs_dat_i = 32'd0;
        bus_if.wbs_adr_i = 32'd0;
        do_reset();

        // Reset state
        @(negedge wb_clk_i);
        chk("rst_active",  {24'd0, active_project}, 32'd0);
        chk("rst_blank",   {31'd0, io_blank}, 32'd0);
        chk("rst_prst",    {31'd0, proj_reset_o}, 32'd0);
        chk("rst_done",    {31'd0, switch_done}, 32'd0);
        chk("rst_ack",     {31'd0, bus_if.wbs_ack_o}, 32'd0);
        chk("rst_dat",     bus_if.wbs_dat_o, 32'd0);
        rd(8'h00, 32'd0);
        rd(8'h04, 32'd0);
        rd(8'h08, 32'h0010_0000);
        rd(8'h0C, 32'd0);

        // Auto rotation over MASK=0x05 with DWELL=20: 0 -> 2 -> 0 -> 2
        wr(8'h04, 32'h05);
        wr(8'h08, 32'd20);
        sw_q.push_back(8'd2);
        wr(8'h00, 32'h1);
        wait_done("done_to_2a");
        sw_q.push_back(8'd0);
        measure_dwell("dwell_20", 20);
        wait_done("done_to_0");
        sw_q.push_back(8'd2);
        wait_done("done_to_2b");

        // Manual request during rotation overrides the mask order
        sw_q.push_back(8'd6);
        wr(8'h00, 32'h0000_0603);
        wait_done("done_manual_6");
        wr(8'h00, 32'h0000_0600);
        rd(8'h0C, 32'h0000_0006);
        rd(8'h00, 32'h0000_0600);

        // Re-reset of the current project still runs a full sequence
        sw_q.push_back(8'd6);
        wr(8'h00, 32'h0000_0602);
        wait_done("done_rereset_6");

        // Partial write ignored, unmapped read is zero, out-of-window ignored
        bus(c_BASE + 32'h04, 1'b1, 4'h3, 32'hFF, 1'b1);
        rd(8'h04, 32'h05);
        rd(8'h40, 32'd0);
        bus(32'h3000_0700, 1'b0, 4'hF, 32'd0, 1'b0);
        bus(32'h3000_0700, 1'b1, 4'hF, 32'hFF, 1'b0);

        // Single enabled project: one switch then steady
        do_reset();
        wr(8'h04, 32'h08);
        wr(8'h08, 32'd20);
        sw_q.push_back(8'd3);
        wr(8'h00, 32'h1);
        wait_done("done_to_3");
        seen = 1'b0;
        repeat (70) begin
            @(negedge wb_clk_i);
            if (io_blank) seen = 1'b1;
        end
        chk("no_reswitch", {31'd0, seen}, 32'd0);

        // DWELL below the minimum is clamped to 16
        do_reset();
        wr(8'h04, 32'h06);
        wr(8'h08, 32'd3);
        sw_q.push_back(8'd1);
        wr(8'h00, 32'h1);
        wait_done("done_to_1");
        sw_q.push_back(8'd2);
        measure_dwell("dwell_min16", 16);
        wait_done("done_to_2c");

        // Reset in the third GUARD cycle aborts the switch to project 1
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (io_blank) seen = 1'b1;
        end
        chk("guard_entry", {31'd0, seen}, 32'd1);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("abort_active", {24'd0, active_project}, 32'd0);
        chk("abort_blank",  {31'd0, io_blank}, 32'd0);
        chk("abort_prst",   {31'd0, proj_reset_o}, 32'd0);
        chk("abort_done",   {31'd0, switch_done}, 32'd0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        rd(8'h0C, 32'd0);
        rd(8'h00, 32'd0);
        repeat (30) @(negedge wb_clk_i);

        chk("rd_q_empty", rd_q.size(), 32'd0);
        chk("sw_q_empty", sw_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/project_sequencer.md
PROJECT_SEQUENCER -- requirements
Module: project_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h30000600, register block base.
REQ-002 SHALL have parameter NUM_PROJECTS, default 8, number of selectable projects.
REQ-003 SHALL have parameter GUARD_CYCLES, default 4, blanking cycles before a switch.
REQ-004 SHALL have parameter RST_CYCLES, default 8, reset hold cycles after a switch.
REQ-005 SHALL have one clock and one synchronous active-high reset; ports: wb_clk_i in 1, clock; wb_rst_i in 1, synchronous active-high reset.
REQ-006 SHALL have ports wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_dat_i in 32; wbs_adr_i in 32: Wishbone slave inputs.
REQ-007 SHALL have ports wbs_ack_o out 1, ack; wbs_dat_o out 32, read data.
REQ-008 SHALL have port active_project out 8, selected project index driving the harness mux.
REQ-009 SHALL have port io_blank out 1, high forces all oeb to 1 and all project inputs to 0.
REQ-010 SHALL have port proj_reset_o out 1, reset to the newly selected project.
REQ-011 SHALL have port switch_done out 1, one-cycle pulse when a switch completes.

Function
REQ-012 SHALL decode registers: BASE+0 CTRL (bit0 auto_en, bit1 manual_req write-only self-clearing, bits[10:8] manual_target); BASE+4 MASK[7:0]; BASE+8 DWELL[31:0]; BASE+C STATUS read-only ({14'b0, state[1:0], 8'b0, active_project}).
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after wbs_cyc_i&wbs_stb_i is first seen, for any address BASE..BASE+0xFC; other addresses are never acked.
REQ-014 SHALL apply writes only when wbs_sel_i==4'hF; partial writes are acked and ignored.
REQ-015 SHALL return 0 for reads of unmapped offsets in the block; wbs_dat_o is 0 whenever wbs_ack_o is low.
REQ-016 SHALL implement states IDLE, RUN, GUARD, RESET (encoded 0-3).
REQ-017 IDLE: auto_en=1 with MASK!=0 -> GUARD; pending manual request -> GUARD; else stay.
REQ-018 RUN: dwell counter increments each cycle; at count==max(DWELL,16)-1 with auto_en: if next project differs from current -> GUARD, else counter restarts at 0; auto_en cleared -> IDLE.
REQ-019 Next project SHALL be the lowest set MASK bit strictly above active_project, wrapping to bit 0; bits >= NUM_PROJECTS ignored.
REQ-020 GUARD: io_blank=1 for GUARD_CYCLES cycles, then active_project loads target and state -> RESET.
REQ-021 RESET: io_blank=1 and proj_reset_o=1 for RST_CYCLES cycles, then switch_done pulses one cycle and state -> RUN with counter 0.
REQ-022 Manual request SHALL take priority over auto rotation; target = manual_target, switching even if MASK bit is clear.
REQ-023 manual_req written during GUARD or RESET SHALL be latched (single-deep, last write wins) and served on the first RUN/IDLE cycle.
REQ-024 MASK or DWELL writes during RUN SHALL take effect at the next terminal-count comparison without restarting the counter.
REQ-025 Manual target equal to active_project SHALL still run a full GUARD/RESET sequence (used as project re-reset).

Reset
REQ-026 On wb_rst_i: state IDLE, active_project 0, MASK 0, DWELL 32'h00100000, auto_en 0, pending request 0, counters 0, io_blank 0, proj_reset_o 0, switch_done 0, wbs_ack_o 0, wbs_dat_o 0.
REQ-027 Reset asserted mid-GUARD/RESET SHALL abort immediately to reset values next cycle, no switch_done.

Structure
REQ-028 SHALL place register offsets, state encoding and DWELL minimum (16) in a shared package harness_pkg.
REQ-029 SHALL use one sub-module, next_project_picker (combinational priority rotate over MASK).

Verification
REQ-030 Reset, MASK=8'h05, DWELL=20, auto_en=1 -> active_project sequence 0,2,0,2; each switch io_blank high 12 cycles, proj_reset_o high final 8, switch_done one pulse.
REQ-031 MASK=8'h08 only, auto_en=1 -> one switch to 3, then no further switches; counter restarts every 20 cycles.
REQ-032 DWELL=3 -> effective dwell 16 cycles between RUN entry and GUARD entry.
REQ-033 In RUN on project 2, write CTRL manual_req target 6 during auto rotation -> next switch goes to 6, not next MASK bit.
REQ-034 Write with wbs_sel_i=4'h3 to MASK -> ack one cycle, MASK unchanged; read BASE+0x40 -> ack, data 0; access 32'h30000700 -> no ack.
REQ-035 Assert wb_rst_i on 3rd GUARD cycle -> next cycle state IDLE, active_project 0, io_blank 0, no switch_done.
